ysyx_23060061_lsu: RTL and testbench

//  Multi-cycle load/store unit directly downstream of the core's EX stage: takes the ALU

---
 rtl/ysyx_23060061_lsu.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_23060061_lsu.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_lsu.sv
// Multi-cycle load/store unit: one valid/ready data-memory transaction per op,
// with byte-lane steering for stores and shift/extend for loads.
module ysyx_23060061_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsuState_t;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  // Completing in this bus cycle still lands resp_valid TIMEOUT cycles after accept.
  localparam logic [CNT_W-1:0] LAST_BUS_CYCLE = CNT_W'(TIMEOUT - 2);

  function automatic logic opLegal(input logic wen, input logic [2:0] funct3,
                                   input logic [1:0] offset);
    case (funct3)
      3'b000:  opLegal = 1'b1;
      3'b001:  opLegal = ~offset[0];
      3'b010:  opLegal = (offset == 2'b00);
      3'b100:  opLegal = ~wen;
      3'b101:  opLegal = ~wen & ~offset[0];
      default: opLegal = 1'b0;
    endcase
  endfunction

  lsuState_t       state;
  lsuState_t       nextState;
  logic            wenReg;
  logic [2:0]      funct3Reg;
  logic [31:0]     addrReg;
  logic [31:0]     wdataReg;
  logic [31:0]     rdataReg;
  logic            errReg;
  logic [CNT_W-1:0] waitCount;

  logic            accept;
  logic            reqLegal;
  logic            timeoutHit;
  logic [1:0]      offset;
  logic [3:0]      storeMask;
  logic [31:0]     storeData;
  logic [31:0]     shiftedWord;
  logic [31:0]     loadData;

  assign accept     = (state == IDLE) & req_valid;
  assign reqLegal   = opLegal(req_wen, req_funct3, req_addr[1:0]);
  assign timeoutHit = (waitCount == LAST_BUS_CYCLE);
  assign offset     = addrReg[1:0];

  // Replicate store data across lanes so the mask alone selects the bytes written.
  always_comb begin
    storeMask = 4'b1111;
    storeData = wdataReg;
    case (funct3Reg[1:0])
      2'b00: begin
        storeMask = 4'b0001 << offset;
        storeData = {4{wdataReg[7:0]}};
      end
      2'b01: begin
        storeMask = 4'b0011 << offset;
        storeData = {2{wdataReg[15:0]}};
      end
      default: begin
        storeMask = 4'b1111;
        storeData = wdataReg;
      end
    endcase
  end

  always_comb begin
    shiftedWord = bus_rdata >> {offset, 3'b000};
    loadData    = shiftedWord;
    case (funct3Reg)
      3'b000:  loadData = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
      3'b001:  loadData = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
      3'b100:  loadData = {24'd0, shiftedWord[7:0]};
      3'b101:  loadData = {16'd0, shiftedWord[15:0]};
      default: loadData = shiftedWord;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A bus completion in the final allowed cycle takes priority over the timeout.
  always_comb begin
    nextState  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    busy       = 1'b0;
    bus_valid  = 1'b0;
    bus_wen    = 1'b0;
    bus_addr   = 32'd0;
    bus_wdata  = 32'd0;
    bus_wmask  = 4'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          nextState = reqLegal ? REQ : RESP;
        end
      end
      REQ: begin
        busy      = 1'b1;
        bus_valid = 1'b1;
        bus_wen   = wenReg;
        bus_addr  = {addrReg[31:2], 2'b00};
        bus_wdata = wenReg ? storeData : 32'd0;
        bus_wmask = wenReg ? storeMask : 4'd0;
        if (bus_ready) begin
          nextState = wenReg ? RESP : WAIT;
        end else if (timeoutHit) begin
          nextState = RESP;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (bus_rvalid || timeoutHit) begin
          nextState = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdataReg;
        resp_err   = errReg;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wenReg    <= 1'b0;
      funct3Reg <= 3'd0;
      addrReg   <= 32'd0;
      wdataReg  <= 32'd0;
      rdataReg  <= 32'd0;
      errReg    <= 1'b0;
      waitCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wenReg    <= req_wen;
            funct3Reg <= req_funct3;
            addrReg   <= req_addr;
            wdataReg  <= req_wdata;
            rdataReg  <= 32'd0;
            errReg    <= ~reqLegal;
            waitCount <= '0;
          end
        end
        REQ: begin
          waitCount <= waitCount + CNT_W'(1);
          if (!bus_ready && timeoutHit) begin
            errReg <= 1'b1;
          end
        end
        WAIT: begin
          waitCount <= waitCount + CNT_W'(1);
          if (bus_rvalid) begin
            rdataReg <= loadData;
          end else if (timeoutHit) begin
            errReg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Bench for the load/store unit: directed vector table, randomized ops checked
// against a byte-level reference model, plus reset and back-to-back sequences.
module tb_ysyx_23060061_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_23060061_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memWord;
    int          readyDelay;
    int          rvalidDelay;
  } op_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          latency;
    logic        busExpected;
    logic [31:0] busAddr;
    logic [3:0]  mask;
    logic [31:0] busWdata;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  typedef struct {
    int          latency;
    int          respCount;
    logic        err;
    logic [31:0] rdata;
    int          busCycles;
    logic        handshake;
    logic [31:0] busAddr;
    logic [3:0]  mask;
    logic [31:0] busWdata;
    logic        busWen;
    int          protoErrs;
  } obs_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic op_t mkOp(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] memWord,
                               input int readyDelay, input int rvalidDelay);
    op_t o;
    o.wen = wen; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.memWord = memWord;
    o.readyDelay = readyDelay; o.rvalidDelay = rvalidDelay;
    return o;
  endfunction

  function automatic exp_t mkExp(input logic err, input logic [31:0] rdata, input int latency,
                                 input logic busExpected, input logic [31:0] busAddr,
                                 input logic [3:0] mask, input logic [31:0] busWdata);
    exp_t e;
    e.err = err; e.rdata = rdata; e.latency = latency; e.busExpected = busExpected;
    e.busAddr = busAddr; e.mask = mask; e.busWdata = busWdata;
    return e;
  endfunction

  task automatic addVec(input op_t op, input exp_t e);
    vec_t v;
    v.op = op;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Reference model: reasons in bytes and cycle budgets, not in FSM states.
  function automatic exp_t refModel(input op_t op);
    exp_t e;
    int size;
    int off;
    int needed;
    logic legal;
    longint raw;
    longint widthMask;
    off  = int'(op.addr[1:0]);
    size = (op.f3[1:0] == 2'b00) ? 1 : (op.f3[1:0] == 2'b01) ? 2 : 4;
    if (op.wen) legal = (op.f3 <= 3'd2);
    else        legal = (op.f3 <= 3'd2) || (op.f3 == 3'd4) || (op.f3 == 3'd5);
    legal = legal && ((off % size) == 0);
    e = mkExp(1'b1, 32'd0, 1, 1'b0, 32'd0, 4'd0, 32'd0);
    if (!legal) return e;
    e.busExpected = 1'b1;
    e.busAddr = op.addr & 32'hFFFF_FFFC;
    needed = op.wen ? op.readyDelay + 1 : op.readyDelay + op.rvalidDelay + 2;
    if (needed <= TIMEOUT - 1) begin
      e.err = 1'b0;
      e.latency = needed + 1;
    end else begin
      e.latency = TIMEOUT;
    end
    if (op.wen) begin
      for (int i = 0; i < 4; i++) begin
        e.mask[i] = (i >= off) && (i < off + size);
        e.busWdata[8*i +: 8] = op.wdata[8*(i % size) +: 8];
      end
    end else if (!e.err) begin
      widthMask = (64'sd1 <<< (8 * size)) - 1;
      raw = (longint'(op.memWord) >>> (8 * off)) & widthMask;
      if (!op.f3[2] && size < 4 && raw >= (widthMask + 1) / 2) raw = raw - (widthMask + 1);
      e.rdata = raw[31:0];
    end
    return e;
  endfunction

  // Drives one op and plays the memory, recording what the DUT did.
  task automatic applyStimulus(input op_t op, output obs_t o);
    logic respSeen = 1'b0;
    logic firstSet = 1'b0;
    logic readPending = 1'b0;
    int validCycles = 0;
    int rvalidWait = 0;
    logic [31:0] fAddr = '0;
    logic [31:0] fWdata = '0;
    logic [3:0] fMask = '0;
    o.latency = 0; o.respCount = 0; o.err = 1'b0; o.rdata = '0; o.busCycles = 0;
    o.handshake = 1'b0; o.busAddr = '0; o.mask = '0; o.busWdata = '0; o.busWen = 1'b0;
    o.protoErrs = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = op.wen; req_funct3 = op.f3;
    req_addr = op.addr; req_wdata = op.wdata;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    if (req_ready !== 1'b1) o.protoErrs++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      bus_ready = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata = ~op.memWord;
      if (busy !== (!respSeen && !resp_valid)) o.protoErrs++;
      if (req_ready !== respSeen) o.protoErrs++;
      if (!resp_valid && (resp_err !== 1'b0 || resp_rdata !== 32'd0)) o.protoErrs++;
      if (resp_valid) begin
        o.respCount++;
        if (!respSeen) begin
          o.latency = k; o.err = resp_err; o.rdata = resp_rdata;
        end
      end
      if (bus_valid) begin
        if (respSeen) o.protoErrs++;
        o.busCycles++;
        if (!firstSet) begin
          firstSet = 1'b1; fAddr = bus_addr; fWdata = bus_wdata; fMask = bus_wmask;
        end else if (bus_addr !== fAddr || bus_wdata !== fWdata || bus_wmask !== fMask) begin
          o.protoErrs++;
        end
        if (validCycles == op.readyDelay) begin
          bus_ready = 1'b1;
          bus_rvalid = 1'b1;
          o.handshake = 1'b1;
          o.busAddr = bus_addr; o.mask = bus_wmask; o.busWdata = bus_wdata; o.busWen = bus_wen;
          readPending = !bus_wen;
          rvalidWait = 0;
        end
        validCycles++;
      end else if (readPending) begin
        if (rvalidWait == op.rvalidDelay) begin
          bus_rvalid = 1'b1;
          bus_rdata = op.memWord;
          readPending = 1'b0;
        end
        rvalidWait++;
      end
      if (resp_valid) respSeen = 1'b1;
      if (respSeen && k >= o.latency + 2) break;
    end
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  task automatic compareOp(input string tag, input op_t op, input exp_t e, input obs_t o);
    checkOutput({tag, " latency"}, o.latency, e.latency);
    checkOutput({tag, " respCount"}, o.respCount, 1);
    checkOutput({tag, " err"}, {31'd0, o.err}, {31'd0, e.err});
    checkOutput({tag, " rdata"}, o.rdata, e.rdata);
    checkOutput({tag, " protocol"}, o.protoErrs, 0);
    if (!e.busExpected) begin
      checkOutput({tag, " busCycles"}, o.busCycles, 0);
    end else if (!e.err) begin
      checkOutput({tag, " handshake"}, {31'd0, o.handshake}, 1);
      checkOutput({tag, " busAddr"}, o.busAddr, e.busAddr);
      checkOutput({tag, " busWen"}, {31'd0, o.busWen}, {31'd0, op.wen});
      checkOutput({tag, " wmask"}, {28'd0, o.mask}, {28'd0, e.mask});
      if (op.wen) checkOutput({tag, " busWdata"}, o.busWdata, e.busWdata);
    end
  endtask

  initial begin
    obs_t o;
    op_t  op;
    logic [5:0] readyBits;
    logic [5:0] respBits;
    logic [5:0] errBits;
    int accepts;
    int strayResp;
    logic pendingSwitch;
    logic pendingDrop;

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    addVec(mkOp(1, 3'b010, 32'h80000104, 32'hDEADBEEF, 0, 3, 0),
           mkExp(0, 0, 5, 1, 32'h80000104, 4'hF, 32'hDEADBEEF));
    addVec(mkOp(1, 3'b000, 32'h80000003, 32'h000000A5, 0, 0, 0),
           mkExp(0, 0, 2, 1, 32'h80000000, 4'h8, 32'hA5A5A5A5));
    addVec(mkOp(0, 3'b000, 32'h80000003, 0, 32'hA5000000, 0, 0),
           mkExp(0, 32'hFFFFFFA5, 3, 1, 32'h80000000, 4'h0, 0));
    addVec(mkOp(0, 3'b101, 32'h80000002, 0, 32'h80011234, 0, 0),
           mkExp(0, 32'h00008001, 3, 1, 32'h80000000, 4'h0, 0));
    addVec(mkOp(0, 3'b001, 32'h80000002, 0, 32'h80011234, 0, 0),
           mkExp(0, 32'hFFFF8001, 3, 1, 32'h80000000, 4'h0, 0));
    addVec(mkOp(0, 3'b010, 32'h80000101, 0, 0, 0, 0), mkExp(1, 0, 1, 0, 0, 0, 0));
    addVec(mkOp(0, 3'b010, 32'h80000010, 0, 32'h12345678, 255, 0),
           mkExp(1, 0, TIMEOUT, 1, 32'h80000010, 4'h0, 0));
    addVec(mkOp(0, 3'b011, 32'h80000000, 0, 0, 0, 0), mkExp(1, 0, 1, 0, 0, 0, 0));
    addVec(mkOp(1, 3'b001, 32'h80000002, 32'h1234ABCD, 0, 1, 0),
           mkExp(0, 0, 3, 1, 32'h80000000, 4'hC, 32'hABCDABCD));
    addVec(mkOp(0, 3'b100, 32'h80000001, 0, 32'h0000F600, 1, 2),
           mkExp(0, 32'h000000F6, 6, 1, 32'h80000000, 4'h0, 0));
    addVec(mkOp(1, 3'b100, 32'h80000000, 32'h11, 0, 0, 0), mkExp(1, 0, 1, 0, 0, 0, 0));
    addVec(mkOp(0, 3'b010, 32'h80000020, 0, 32'hCAFEF00D, 2, 4),
           mkExp(0, 32'hCAFEF00D, 9, 1, 32'h80000020, 4'h0, 0));
    addVec(mkOp(1, 3'b010, 32'h80000040, 32'h0BADF00D, 0, 14, 0),
           mkExp(0, 0, 16, 1, 32'h80000040, 4'hF, 32'h0BADF00D));
    addVec(mkOp(1, 3'b010, 32'h80000040, 32'h0BADF00D, 0, 15, 0),
           mkExp(1, 0, 16, 1, 32'h80000040, 4'hF, 32'h0BADF00D));
    addVec(mkOp(0, 3'b001, 32'h80000001, 0, 0, 0, 0), mkExp(1, 0, 1, 0, 0, 0, 0));
    addVec(mkOp(0, 3'b010, 32'h80000044, 0, 32'h5A5A0FF0, 0, 13),
           mkExp(0, 32'h5A5A0FF0, 16, 1, 32'h80000044, 4'h0, 0));
    addVec(mkOp(0, 3'b010, 32'h80000044, 0, 32'h5A5A0FF0, 0, 14),
           mkExp(1, 0, 16, 1, 32'h80000044, 4'h0, 0));

    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", {31'd0, req_ready}, 1);
    checkOutput("reset busy", {31'd0, busy}, 0);
    checkOutput("reset resp_valid", {31'd0, resp_valid}, 0);
    checkOutput("reset resp", {resp_err, resp_rdata[30:0]}, 0);
    checkOutput("reset bus_valid", {31'd0, bus_valid}, 0);
    checkOutput("reset bus fields", bus_addr | bus_wdata | {27'd0, bus_wen, bus_wmask}, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, o);
      compareOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp, o);
    end

    for (int i = 0; i < 80; i++) begin
      op.wen = 1'($urandom_range(0, 1));
      op.f3 = 3'($urandom_range(0, 7));
      op.addr = $urandom;
      op.wdata = $urandom;
      op.memWord = $urandom;
      op.readyDelay = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 3);
      op.rvalidDelay = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 14) : $urandom_range(0, 3);
      applyStimulus(op, o);
      compareOp($sformatf("rand%0d", i), op, refModel(op), o);
    end

    // Reset while a load waits for data: the op vanishes without a response.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000030;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstWait bus_valid in REQ", {31'd0, bus_valid}, 1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    checkOutput("rstWait busy in WAIT", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstWait req_ready", {31'd0, req_ready}, 1);
    checkOutput("rstWait busy", {31'd0, busy}, 0);
    checkOutput("rstWait bus_valid", {31'd0, bus_valid}, 0);
    strayResp = resp_valid ? 1 : 0;
    bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
    repeat (3) begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      if (resp_valid) strayResp++;
    end
    checkOutput("rstWait stray resp_valid", strayResp, 0);
    op = mkOp(0, 3'b010, 32'h80000030, 0, 32'h13579BDF, 1, 1);
    applyStimulus(op, o);
    compareOp("afterRst", op, refModel(op), o);

    // Back-to-back with req_valid held: a store, then an illegal funct3 once IDLE returns.
    readyBits = '0; respBits = '0; errBits = '0;
    accepts = 0; pendingSwitch = 1'b0; pendingDrop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h80000050; req_wdata = 32'h11223344;
      end
      if (pendingSwitch) begin
        req_wen = 1'b0; req_funct3 = 3'b011; req_addr = 32'h80000060; pendingSwitch = 1'b0;
      end
      if (pendingDrop) begin
        req_valid = 1'b0; pendingDrop = 1'b0;
      end
      bus_ready = bus_valid;
      readyBits[k] = req_ready;
      respBits[k] = resp_valid;
      errBits[k] = resp_err;
      if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 1) pendingSwitch = 1'b1;
        else pendingDrop = 1'b1;
      end
    end
    bus_ready = 1'b0;
    checkOutput("b2b req_ready trace", {26'd0, readyBits}, {26'd0, 6'b101001});
    checkOutput("b2b resp_valid trace", {26'd0, respBits}, {26'd0, 6'b010100});
    checkOutput("b2b resp_err trace", {26'd0, errBits}, {26'd0, 6'b010000});
    checkOutput("b2b accepts", accepts, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
